mem_stage: RTL and testbench

- Pipeline stage directly downstream of the execute stage.
- Registers the execute-to-memory bus and receives synchronous data-SRAM read data one cycle after the address was issued.
- Performs load byte/halfword extraction with sign/zero extension, then produces the memory-to-writeback bus plus GPR and HI/LO forwarding outputs for the decode stage.
- Includes a read-data hold buffer so load data survives while the stage is stalled.

---
 rtl/mem_stage_pkg.sv | 54 +++++
 rtl/mem_stage_load_align.sv | 41 ++++
 rtl/mem_stage.sv | 115 +++++++++++
 tb/tb_mem_stage.sv | 215 +++++++++++++++++++++
 4 files changed

// File: rtl/mem_stage_pkg.sv
// Shared widths, stall encodings and bus layouts for the memory stage.
// Optional misaligned-load detection is built when MEM_ADEL_CHECK_EN is defined.
package mem_stage_pkg;

    localparam int unsigned STALL_W      = 6;
    localparam int unsigned EX_TO_MEM_WD = 146;
    localparam int unsigned MEM_TO_WB_WD = 136;

    localparam logic STOP    = 1'b1;
    localparam logic NO_STOP = 1'b0;

    localparam int unsigned STALL_MEM = 3;
    localparam int unsigned STALL_WB  = 4;

    // Field offsets (LSB positions) of the memory-to-writeback bus.
    localparam int unsigned M2W_RF_WDATA = 0;
    localparam int unsigned M2W_RF_WADDR = 32;
    localparam int unsigned M2W_RF_WE    = 37;
    localparam int unsigned M2W_PC       = 38;
    localparam int unsigned M2W_LO       = 70;
    localparam int unsigned M2W_HI       = 102;
    localparam int unsigned M2W_WE_LO    = 134;
    localparam int unsigned M2W_WE_HI    = 135;

    typedef struct packed {
        logic        lb;
        logic        lbu;
        logic        lh;
        logic        lhu;
        logic        we_hi;
        logic        we_lo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] pc;
        logic        ram_en;
        logic [3:0]  ram_wen;
        logic        sel_rf_res;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] ex_result;
    } ex_to_mem_t;

    typedef struct packed {
        logic        we_hi;
        logic        we_lo;
        logic [31:0] hi;
        logic [31:0] lo;
        logic [31:0] pc;
        logic        rf_we;
        logic [4:0]  rf_waddr;
        logic [31:0] rf_wdata;
    } mem_to_wb_t;

endpackage

// File: rtl/mem_stage_load_align.sv
// Load data extraction: selects byte/halfword from the read word and extends it.
module mem_stage_load_align (
    input  logic [31:0] rd_i,
    input  logic [1:0]  offset_i,
    input  logic        lb_i,
    input  logic        lbu_i,
    input  logic        lh_i,
    input  logic        lhu_i,
    input  logic        sel_rf_res_i,
    output logic [31:0] res_o
);

    logic [7:0]  byte_sel;
    logic [15:0] half_sel;

    always_comb begin
        byte_sel = rd_i[7:0];
        unique case (offset_i)
            2'd0: byte_sel = rd_i[7:0];
            2'd1: byte_sel = rd_i[15:8];
            2'd2: byte_sel = rd_i[23:16];
            2'd3: byte_sel = rd_i[31:24];
            default: byte_sel = rd_i[7:0];
        endcase
        half_sel = offset_i[1] ? rd_i[31:16] : rd_i[15:0];
    end

    always_comb begin
        res_o = '0;
        if (sel_rf_res_i) begin
            if (lb_i || lbu_i) begin
                res_o = {{24{lb_i & byte_sel[7]}}, byte_sel};
            end else if (lh_i || lhu_i) begin
                res_o = {{16{lh_i & half_sel[15]}}, half_sel};
            end else begin
                res_o = rd_i;
            end
        end
    end

endmodule

// File: rtl/mem_stage.sv
// Memory pipeline stage: registers the execute bus, extracts load data (with a stall
// hold buffer) and drives writeback/forwarding. MEM_ADEL_CHECK_EN enables misaligned-load flagging.
module mem_stage
    import mem_stage_pkg::*;
#(
    parameter int unsigned EX_TO_MEM_WD = 146,
    parameter int unsigned MEM_TO_WB_WD = 136,
    parameter int unsigned STALL_W      = 6
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [STALL_W-1:0]      stall,
    input  logic [EX_TO_MEM_WD-1:0] ex_to_mem_bus,
    input  logic [31:0]             data_sram_rdata,
    output logic [MEM_TO_WB_WD-1:0] mem_to_wb_bus,
    output logic                    fwd_mem_we,
    output logic [4:0]              fwd_mem_addr,
    output logic [31:0]             fwd_mem_data,
    output logic                    fwd_mem_we_hi,
    output logic                    fwd_mem_we_lo,
    output logic [31:0]             fwd_mem_hi,
    output logic [31:0]             fwd_mem_lo,
    output logic                    mem_adel
);

    logic [EX_TO_MEM_WD-1:0] bus_q, bus_d;
    logic [31:0]             rdata_hold_q, rdata_hold_d;
    logic                    hold_vld_q, hold_vld_d;
    ex_to_mem_t              ex;
    mem_to_wb_t              wb;
    logic                    is_load;
    logic                    plain_lw;
    logic [31:0]             rd;
    logic [31:0]             load_data;
    logic                    rf_we_eff;

    assign ex       = bus_q;
    assign is_load  = ex.ram_en & (ex.ram_wen == 4'b0000) & ex.sel_rf_res;
    assign plain_lw = ~(ex.lb | ex.lbu | ex.lh | ex.lhu);
    assign rd       = hold_vld_q ? rdata_hold_q : data_sram_rdata;

    always_comb begin
        bus_d = bus_q;
        if (stall[STALL_MEM] == STOP && stall[STALL_WB] == NO_STOP) begin
            bus_d = '0;
        end else if (stall[STALL_MEM] == NO_STOP) begin
            bus_d = ex_to_mem_bus;
        end
    end

    // Read data arrives only in the first MEM cycle; keep it while the stage is frozen.
    always_comb begin
        hold_vld_d   = hold_vld_q;
        rdata_hold_d = rdata_hold_q;
        if (stall[STALL_MEM] == NO_STOP || stall[STALL_WB] == NO_STOP) begin
            hold_vld_d = 1'b0;
        end else if (is_load && !hold_vld_q) begin
            hold_vld_d   = 1'b1;
            rdata_hold_d = data_sram_rdata;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            bus_q        <= '0;
            hold_vld_q   <= 1'b0;
            rdata_hold_q <= '0;
        end else begin
            bus_q        <= bus_d;
            hold_vld_q   <= hold_vld_d;
            rdata_hold_q <= rdata_hold_d;
        end
    end

    mem_stage_load_align u_load_align (
        .rd_i        (rd),
        .offset_i    (ex.ex_result[1:0]),
        .lb_i        (ex.lb),
        .lbu_i       (ex.lbu),
        .lh_i        (ex.lh),
        .lhu_i       (ex.lhu),
        .sel_rf_res_i(ex.sel_rf_res),
        .res_o       (load_data)
    );

`ifdef MEM_ADEL_CHECK_EN
    assign mem_adel = is_load & (((ex.lh | ex.lhu) & ex.ex_result[0]) |
                                 (plain_lw & (ex.ex_result[1:0] != 2'b00)));
`else
    assign mem_adel = 1'b0;
`endif

    assign rf_we_eff = ex.rf_we & ~mem_adel;

    always_comb begin
        wb.we_hi    = ex.we_hi;
        wb.we_lo    = ex.we_lo;
        wb.hi       = ex.hi;
        wb.lo       = ex.lo;
        wb.pc       = ex.pc;
        wb.rf_we    = rf_we_eff;
        wb.rf_waddr = ex.rf_waddr;
        wb.rf_wdata = is_load ? load_data : ex.ex_result;
    end

    assign mem_to_wb_bus = wb;
    assign fwd_mem_we    = wb.rf_we;
    assign fwd_mem_addr  = wb.rf_waddr;
    assign fwd_mem_data  = wb.rf_wdata;
    assign fwd_mem_we_hi = wb.we_hi;
    assign fwd_mem_we_lo = wb.we_lo;
    assign fwd_mem_hi    = wb.hi;
    assign fwd_mem_lo    = wb.lo;

endmodule

// File: tb/tb_mem_stage.sv
// Directed bench for mem_stage: reset, load extraction, stall hold, bubble, misaligned loads.
module tb_mem_stage;

    logic         clk;
    logic         rst;
    logic [5:0]   stall;
    logic [145:0] ex_bus;
    logic [31:0]  rdata;
    logic [135:0] wb;
    logic         f_we, f_we_hi, f_we_lo, adel;
    logic [4:0]   f_addr;
    logic [31:0]  f_data, f_hi, f_lo;

    int n_checks = 0;
    int n_errors = 0;

    mem_stage dut (
        .clk            (clk),
        .rst            (rst),
        .stall          (stall),
        .ex_to_mem_bus  (ex_bus),
        .data_sram_rdata(rdata),
        .mem_to_wb_bus  (wb),
        .fwd_mem_we     (f_we),
        .fwd_mem_addr   (f_addr),
        .fwd_mem_data   (f_data),
        .fwd_mem_we_hi  (f_we_hi),
        .fwd_mem_we_lo  (f_we_lo),
        .fwd_mem_hi     (f_hi),
        .fwd_mem_lo     (f_lo),
        .mem_adel       (adel)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_errors++;
            $display("FAIL %s: got 0x%08h expected 0x%08h", tag, act, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Flags packed as {lb,lbu,lh,lhu}.
    function automatic logic [145:0] mk(input logic [3:0] sub, input logic we_hi,
                                        input logic we_lo, input logic [31:0] hi,
                                        input logic [31:0] lo, input logic [31:0] pc,
                                        input logic ram_en, input logic [3:0] wen,
                                        input logic sel, input logic rf_we,
                                        input logic [4:0] waddr, input logic [31:0] res);
        return {sub, we_hi, we_lo, hi, lo, pc, ram_en, wen, sel, rf_we, waddr, res};
    endfunction

    function automatic logic [145:0] ld(input logic [3:0] sub, input logic [31:0] addr,
                                        input logic [31:0] pc, input logic [4:0] waddr);
        return mk(sub, 1'b0, 1'b0, 32'h0, 32'h0, pc, 1'b1, 4'h0, 1'b1, 1'b1, waddr, addr);
    endfunction

    localparam logic [3:0] LB = 4'b1000, LBU = 4'b0100, LH = 4'b0010, LHU = 4'b0001;
    localparam logic [3:0] LW = 4'b0000;

    logic exp_adel;

    initial begin
        rst    = 1'b1;
        stall  = '0;
        ex_bus = ld(LW, 32'h1234, 32'h55, 5'd3);
        rdata  = 32'hFFFF_FFFF;
        tick();
        tick();
        check("rst_wb_any", {31'b0, |wb}, 32'h0);
        check("rst_fwd_we", {31'b0, f_we | f_we_hi | f_we_lo}, 32'h0);
        check("rst_fwd_data", f_data, 32'h0);
        check("rst_fwd_hilo", f_hi | f_lo | {27'b0, f_addr}, 32'h0);
        check("rst_adel", {31'b0, adel}, 32'h0);
        rst = 1'b0;

        // Byte loads
        ex_bus = ld(LB, 32'h103, 32'h100, 5'd5);
        tick();
        rdata = 32'h80AA55CC;
        #1;
        check("lb_103", wb[31:0], 32'hFFFF_FF80);
        check("lb_fwd_data", f_data, 32'hFFFF_FF80);
        check("lb_fwd_we", {31'b0, f_we}, 32'h1);
        check("lb_fwd_addr", {27'b0, f_addr}, 32'd5);
        check("lb_pc", wb[69:38], 32'h100);
        ex_bus = ld(LBU, 32'h103, 32'h104, 5'd6);
        tick();
        check("lbu_103", wb[31:0], 32'h0000_0080);
        ex_bus = ld(LB, 32'h101, 32'h108, 5'd6);
        tick();
        check("lb_101", wb[31:0], 32'h0000_0055);

        // Halfword loads
        ex_bus = ld(LH, 32'h102, 32'h10C, 5'd7);
        tick();
        rdata = 32'h8001_7FFF;
        #1;
        check("lh_102", wb[31:0], 32'hFFFF_8001);
        ex_bus = ld(LHU, 32'h100, 32'h110, 5'd7);
        tick();
        check("lhu_100", wb[31:0], 32'h0000_7FFF);
        ex_bus = ld(LH, 32'h100, 32'h114, 5'd7);
        tick();
        check("lh_100", wb[31:0], 32'h0000_7FFF);

        // ALU op with HI write: result passes through
        ex_bus = mk(LW, 1'b1, 1'b0, 32'hAAAA_0001, 32'h0000_5555, 32'h118, 1'b0, 4'h0,
                    1'b0, 1'b1, 5'd9, 32'hCAFE_F00D);
        tick();
        check("alu_wdata", f_data, 32'hCAFE_F00D);
        check("alu_we_hi", {30'b0, f_we_hi, f_we_lo}, 32'h2);
        check("alu_hi", f_hi, 32'hAAAA_0001);
        check("alu_lo", f_lo, 32'h0000_5555);
        check("alu_wb_hi", wb[133:102], 32'hAAAA_0001);
        check("alu_wb_we", {30'b0, wb[135], wb[134]}, 32'h2);

        // ram_en with no write but not a register load: ex_result, not rdata
        ex_bus = mk(LB, 1'b0, 1'b1, 32'h0, 32'h1, 32'h11C, 1'b1, 4'h0, 1'b0, 1'b0, 5'd0,
                    32'h0000_0203);
        tick();
        check("noload_wdata", wb[31:0], 32'h0000_0203);
        check("noload_we_lo", {31'b0, f_we_lo}, 32'h1);

        // Store: passes through, no register write
        ex_bus = mk(LW, 1'b0, 1'b0, 32'h0, 32'h0, 32'h120, 1'b1, 4'hF, 1'b0, 1'b0, 5'd0,
                    32'h0000_0300);
        tick();
        check("store_wdata", wb[31:0], 32'h0000_0300);
        check("store_we", {31'b0, f_we}, 32'h0);

        // Stall with hold buffer
        ex_bus = ld(LW, 32'h200, 32'h300, 5'd8);
        tick();
        rdata = 32'h1234_5678;
        stall = 6'b011000;
        ex_bus = mk(LW, 1'b0, 1'b0, 32'h0, 32'h0, 32'h304, 1'b0, 4'h0, 1'b0, 1'b1, 5'd10,
                    32'h0BAD_F00D);
        #1;
        check("hold_first", wb[31:0], 32'h1234_5678);
        for (int i = 0; i < 3; i++) begin
            tick();
            rdata = 32'hDEAD_BEEF;
            #1;
            check($sformatf("hold_stall%0d", i), wb[31:0], 32'h1234_5678);
            check($sformatf("hold_pc%0d", i), wb[69:38], 32'h300);
        end
        check("hold_vld_set", {31'b0, dut.hold_vld_q}, 32'h1);
        stall = 6'b000000;
        #1;
        check("hold_release", wb[31:0], 32'h1234_5678);
        tick();
        check("after_release", wb[31:0], 32'h0BAD_F00D);
        check("after_release_vld", {31'b0, dut.hold_vld_q}, 32'h0);

        // Bubble while hold is valid: bubble wins
        ex_bus = ld(LW, 32'h400, 32'h400, 5'd11);
        tick();
        rdata = 32'h0F0F_0F0F;
        stall = 6'b011000;
        tick();
        check("bub_pre_vld", {31'b0, dut.hold_vld_q}, 32'h1);
        stall = 6'b001000;
        tick();
        check("bub_rf_we", {31'b0, wb[37]}, 32'h0);
        check("bub_pc", wb[69:38], 32'h0);
        check("bub_vld", {31'b0, dut.hold_vld_q}, 32'h0);

        // Reset in the middle of a stall
        stall = 6'b000000;
        ex_bus = ld(LW, 32'h500, 32'h500, 5'd12);
        tick();
        stall = 6'b011000;
        tick();
        rst = 1'b1;
        tick();
        check("rstmid_wb_any", {31'b0, |wb}, 32'h0);
        check("rstmid_vld", {31'b0, dut.hold_vld_q}, 32'h0);
        rst = 1'b0;
        stall = 6'b000000;

        // Misaligned loads
`ifdef MEM_ADEL_CHECK_EN
        exp_adel = 1'b1;
`else
        exp_adel = 1'b0;
`endif
        ex_bus = ld(LW, 32'h202, 32'h600, 5'd13);
        tick();
        check("lw202_adel", {31'b0, adel}, {31'b0, exp_adel});
        check("lw202_rf_we", {31'b0, wb[37]}, {31'b0, ~exp_adel});
        check("lw202_fwd_we", {31'b0, f_we}, {31'b0, ~exp_adel});
        ex_bus = ld(LHU, 32'h103, 32'h604, 5'd13);
        tick();
        check("lhu103_adel", {31'b0, adel}, {31'b0, exp_adel});
        ex_bus = ld(LB, 32'h203, 32'h608, 5'd13);
        tick();
        check("lb203_adel", {31'b0, adel}, 32'h0);
        ex_bus = ld(LW, 32'h200, 32'h60C, 5'd13);
        tick();
        check("lw200_adel", {31'b0, adel}, 32'h0);
        check("lw200_rf_we", {31'b0, f_we}, 32'h1);

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
